// File: rtl/l2_msg1_queue_pkg.sv
// Shared widths, message encodings and the queued entry layout for the L2 msg1 channel.
package l2_msg1_queue_pkg;

    localparam int unsigned MSG_WIDTH  = 8;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned TAG_WIDTH  = 8;
    localparam int unsigned OWNER_BITS = 2;

    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_EMPTY = 8'd0;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD  = 8'd1;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE = 8'd2;

    typedef struct packed {
        logic [MSG_WIDTH-1:0]  msg_type;
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
        logic [OWNER_BITS-1:0] source;
    } msg1_entry_t;

    function automatic logic is_request(input logic [MSG_WIDTH-1:0] t);
        return t != MSG_TYPE_EMPTY;
    endfunction

endpackage

// File: rtl/l2_msg1_queue_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count; callers must not write when
// full without reading, nor read when empty.
module ccp_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   CountOne = 1;
    localparam logic [PTR_W-1:0] PtrOne   = 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; consumers gate on count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/l2_msg1_queue.sv
// Channel-1 request buffer: captures every non-empty cluster msg1 into a FIFO and drains it
// to the L2, holding the head while the L2 has an in-flight transaction on the same tag.
module l2_msg1_queue
    import l2_msg1_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MSG_WIDTH-1:0]  msg1_type,
    input  logic [DATA_WIDTH-1:0] msg1_data,
    input  logic [TAG_WIDTH-1:0]  msg1_tag,
    input  logic [OWNER_BITS-1:0] msg1_source,
    input  logic                  lock_valid,
    input  logic [TAG_WIDTH-1:0]  lock_tag,
    input  logic                  req_ready,
    output logic                  req_valid,
    output logic [MSG_WIDTH-1:0]  req_type,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic [TAG_WIDTH-1:0]  req_tag,
    output logic [OWNER_BITS-1:0] req_source,
    output logic [PTR_W:0]        count,
    output logic                  full,
    output logic                  overflow
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    msg1_entry_t    in_entry;
    msg1_entry_t    head;
    logic [PTR_W:0] fifo_count;
    logic           in_req, nonempty, hold, deq, enq;
    logic           overflow_q, overflow_d;

    assign in_entry = '{msg_type: msg1_type, data: msg1_data, tag: msg1_tag,
                        source: msg1_source};

    ccp_sync_fifo #(
        .WIDTH ($bits(msg1_entry_t)),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (enq),
        .wr_data (in_entry),
        .rd_en   (deq),
        .rd_data (head),
        .count   (fifo_count)
    );

    always_comb begin
        in_req    = is_request(msg1_type);
        nonempty  = fifo_count != '0;
        hold      = lock_valid && (lock_tag == head.tag);
        req_valid = nonempty && !hold;
        deq       = req_valid && req_ready;
        // A dequeue in the same cycle frees the slot, so a full queue can still accept.
        enq        = in_req && ((fifo_count != FullCount) || deq);
        overflow_d = overflow_q || (in_req && !enq);

        req_type   = req_valid ? head.msg_type : MSG_TYPE_EMPTY;
        req_data   = nonempty ? head.data : '0;
        req_tag    = nonempty ? head.tag : '0;
        req_source = nonempty ? head.source : '0;
        count      = fifo_count;
        full       = fifo_count == FullCount;
        overflow   = overflow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: doc/l2_msg1_queue.md
# l2_msg1_queue

Channel-1 request buffer between the four-core L1.5 cluster and the L2 directory. Every cycle, the cluster's arbitrated msg1 output (type, data, tag, source) is captured into a FIFO, because the cluster has no backpressure. The FIFO is drained toward the L2 with a valid/ready handshake. The head request is held back while the L2 reports an in-flight transaction on the same tag.

## Interface
Parameters:
- DEPTH, 8 — FIFO entries; power of two, ≥2
- PTR_W, $clog2(DEPTH) — pointer width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- msg1_type  in  `MSG_WIDTH  request type from L1.5 cluster; `MSG_TYPE_EMPTY = no request
- msg1_data  in  `DATA_WIDTH  request data
- msg1_tag  in  `TAG_WIDTH  request tag
- msg1_source  in  `OWNER_BITS  originating core
- lock_valid  in  1  L2 has an in-flight transaction
- lock_tag  in  `TAG_WIDTH  tag of that transaction
- req_ready  in  1  L2 accepts head this cycle
- req_valid  out  1  head request presented
- req_type  out  `MSG_WIDTH  head type; `MSG_TYPE_EMPTY when req_valid=0
- req_data  out  `DATA_WIDTH  head data
- req_tag  out  `TAG_WIDTH  head tag
- req_source  out  `OWNER_BITS  head source
- count  out  PTR_W+1  occupied entries
- full  out  1  count==DEPTH
- overflow  out  1  sticky: a request was dropped

## Operation
- Enqueue condition: msg1_type != `MSG_TYPE_EMPTY and (count<DEPTH or dequeue this cycle). The request is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Dequeue condition: req_valid & req_ready. rd_ptr increments modulo DEPTH.
- count changes by +1 on enqueue only, −1 on dequeue only, and is unchanged when both or neither occur.
- Full with no dequeue and a non-empty msg1: the request is dropped, state is unchanged, and overflow is set on the next edge. It stays 1 until reset.
- Tag hold: req_valid = (count!=0) & !(lock_valid & lock_tag==head tag). A held head blocks all younger entries. There is no reordering, which preserves per-tag ordering.
- When req_valid=0: req_type=`MSG_TYPE_EMPTY. req_data/tag/source show the head entry, or 0 when empty.
- Request types are not interpreted. Any non-empty encoding is stored verbatim.

## Timing
- Reset (asynchronous, effective immediately):
  - rd_ptr, wr_ptr, count, overflow = 0
  - req_valid=0, req_type=`MSG_TYPE_EMPTY, req_data/tag/source=0, full=0
  - Storage contents are don't-care.
- Latency: a request sampled at edge N is presented on req_* after edge N (first-word-fall-through from registered storage). The earliest dequeue is at edge N+1. There is no same-cycle bypass from msg1 to req.
- req_* and req_valid are combinational from registered state plus lock_valid/lock_tag. req_ready must not influence req_valid in the same cycle.
- A lock release (lock_valid falling) makes the held head valid in the same cycle.
- Reset mid-operation: all queued entries are discarded, and no output glitches toward valid during reset.
- Wrap-around: pointers wrap from DEPTH−1 to 0. full and empty are derived from count, not from pointer equality.

## Structure
- `MSG_WIDTH, `DATA_WIDTH, `TAG_WIDTH, `OWNER_BITS and the `MSG_TYPE_* encodings live in the shared ccp_define.h. Nothing block-local goes there.
- One natural sub-module: ccp_sync_fifo, a generic width/depth FWFT FIFO with wr_en/rd_en/count and asynchronous reset, reusable for the msg3 path.
- l2_msg1_queue wraps it with the enqueue filter, overflow flag, and tag-hold gating.

## Test plan
- Single request: reset, then msg1_type=LOAD (non-empty), tag=5, data=0xA, source=2 for one cycle, req_ready=1 → next cycle req_valid=1 with req_tag=5, req_source=2, req_data=0xA. The following cycle req_valid=0, req_type=EMPTY, count=0.
- Fill to full: 8 consecutive non-empty requests with tags 0..7, req_ready=0 → count=8, full=1, overflow=0. A 9th request (tag 9) → overflow=1 and count=8. Then drain with req_ready=1 → tags come out 0..7 in order, and tag 9 never appears.
- Simultaneous at full: at count=8 with req_ready=1 and a new request (tag 12) → count stays 8, overflow stays 0, and tag 12 emerges last.
- Tag hold: head tag=3, lock_valid=1, lock_tag=3, req_ready=1 for 4 cycles → req_valid=0 and count unchanged throughout. Drop lock_valid → req_valid=1 in that same cycle and head tag 3 dequeues at the next edge.
- Non-matching lock: head tag=3, lock_tag=4, lock_valid=1 → req_valid=1 and the head dequeues normally.
- Reset mid-operation: count=5 and overflow=1, assert rst asynchronously between edges → count=0, overflow=0, req_valid=0 immediately. After release, a new request (tag 7) appears one cycle later as the head.
